// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if
//   Bundles the decoder/control-side signals of the SAP1 step sequencer.
//   master: the controller/decoder side (drives mclk_en and the i_* controls,
//           observes the o_* status).
//   slave : the sequencer itself.
//   Signals:
//     mclk_en          clock enable
//     i_len            decoder step count (STEP_WIDTH+1 bits)
//     i_adv, i_stall   early end-of-instruction, wait state
//     i_halt, i_resume halt entry / exit
//     i_single         single-step mode select
//     i_step_req       single-step request
//     o_step           current step index (microcode ROM address)
//     o_fetch, o_last  fetch phase / last step of instruction
//     o_retire         one-tick pulse after an instruction completes
//     o_retired        retired-instruction counter
//     o_halted         sequencer is halted
//     o_paused         sequencer is paused waiting for a step request
interface instruction_sequencer_if #(
   parameter int MAX_STEPS    = 8,
   parameter int RETIRE_WIDTH = 16
);
   localparam int STEP_WIDTH = $clog2(MAX_STEPS);

   logic                    mclk_en;
   logic [STEP_WIDTH:0]     i_len;
   logic                    i_adv;
   logic                    i_stall;
   logic                    i_halt;
   logic                    i_resume;
   logic                    i_single;
   logic                    i_step_req;
   logic [STEP_WIDTH-1:0]   o_step;
   logic                    o_fetch;
   logic                    o_last;
   logic                    o_retire;
   logic [RETIRE_WIDTH-1:0] o_retired;
   logic                    o_halted;
   logic                    o_paused;

   modport master (
      output mclk_en, i_len, i_adv, i_stall, i_halt, i_resume, i_single, i_step_req,
      input  o_step, o_fetch, o_last, o_retire, o_retired, o_halted, o_paused
   );

   modport slave (
      input  mclk_en, i_len, i_adv, i_stall, i_halt, i_resume, i_single, i_step_req,
      output o_step, o_fetch, o_last, o_retire, o_retired, o_halted, o_paused
   );
endinterface

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Microinstruction step sequencer for the SAP1 control path. Steps through
//   variable-length instructions (length from the decoder), supports wait
//   states, early end-of-instruction, a sticky HALT with resume and a
//   single-step debug mode. State changes on the falling edge of mclk,
//   qualified by mclk_en.
//   Ports:
//     mclk     system clock (falling-edge active)
//     i_reset  asynchronous active-high reset
//     bus      instruction_sequencer_if.slave control/status bundle
module instruction_sequencer #(
   parameter int MAX_STEPS    = 8,
   parameter int FETCH_STEPS  = 2,
   parameter int RETIRE_WIDTH = 16
) (
   input  logic                    mclk,
   input  logic                    i_reset,
   instruction_sequencer_if.slave  bus
);
   localparam int STEP_WIDTH = $clog2(MAX_STEPS);

   localparam logic [STEP_WIDTH:0]     MAX_L     = (STEP_WIDTH+1)'(MAX_STEPS);
   localparam logic [STEP_WIDTH:0]     MIN_L     = (STEP_WIDTH+1)'(FETCH_STEPS + 1);
   localparam logic [STEP_WIDTH:0]     ONE_L     = (STEP_WIDTH+1)'(1);
   localparam logic [STEP_WIDTH-1:0]   LAST_STEP = STEP_WIDTH'(MAX_STEPS - 1);
   localparam logic [STEP_WIDTH-1:0]   FETCH_S   = STEP_WIDTH'(FETCH_STEPS);
   localparam logic [STEP_WIDTH-1:0]   STEP_ONE  = STEP_WIDTH'(1);
   localparam logic [RETIRE_WIDTH-1:0] CNT_ONE   = RETIRE_WIDTH'(1);

   typedef enum logic [1:0] {RUN, PAUSE, HALT} state_t;

   state_t                  state;
   logic [STEP_WIDTH-1:0]   step;
   logic [RETIRE_WIDTH-1:0] retired;
   logic                    retire;

   logic [STEP_WIDTH:0]     eff_len;
   logic                    last;
   logic                    step_ev;

   // Decoder length clamped into [FETCH_STEPS+1, MAX_STEPS]; 0 and
   // out-of-range lengths mean "full length".
   always_comb begin
      eff_len = bus.i_len;
      if (bus.i_len == '0 || bus.i_len > MAX_L)
         eff_len = MAX_L;
      else if (bus.i_len < MIN_L)
         eff_len = MIN_L;
   end

   // i_len only matters once past the fetch steps, so the decoder output is
   // free to be garbage during fetch.
   assign last = (step == LAST_STEP) | bus.i_adv |
                 ((step >= FETCH_S) && ({1'b0, step} == (eff_len - ONE_L)));

   assign step_ev = bus.mclk_en & (state == RUN) & ~bus.i_stall &
                    (~bus.i_single | bus.i_step_req);

   always_ff @(negedge mclk or posedge i_reset) begin
      if (i_reset) begin
         state   <= RUN;
         step    <= '0;
         retired <= '0;
         retire  <= 1'b0;
      end else if (bus.mclk_en) begin
         retire <= 1'b0;
         case (state)
            RUN: begin
               if (step_ev) begin
                  if (last) begin
                     step    <= '0;
                     retired <= retired + CNT_ONE;
                     retire  <= 1'b1;
                  end else begin
                     step <= step + STEP_ONE;
                  end
                  // The step completes before halting; HALT beats PAUSE.
                  if (bus.i_halt)
                     state <= HALT;
                  else if (bus.i_single)
                     state <= PAUSE;
               end
            end
            // A request in PAUSE only rearms; the step itself happens on a
            // later request (or right away once single mode is dropped).
            PAUSE: if (~bus.i_single | bus.i_step_req) state <= RUN;
            HALT:  if (bus.i_resume) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   assign bus.o_step    = step;
   assign bus.o_fetch   = (step < FETCH_S);
   assign bus.o_last    = last;
   assign bus.o_retire  = retire;
   assign bus.o_retired = retired;
   assign bus.o_halted  = (state == HALT);
   assign bus.o_paused  = (state == PAUSE);
endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Parametrised microinstruction step sequencer for the SAP1 control path: the next generation of the fixed-length step counter. It supports variable-length instructions from a decoder-supplied length, wait-state stalls, an early end-of-instruction request, a sticky halt state with resume, and a single-step debug mode. It sits between the instruction register/decoder and the microcode ROM; `o_step` addresses the ROM, and the status outputs feed the front panel and the bus controller.

## Interface

Parameters:

- `MAX_STEPS`, default 8: hard upper bound on steps per instruction; must be ≥ 2. `STEP_WIDTH = $clog2(MAX_STEPS)`.
- `FETCH_STEPS`, default 2: number of leading fetch steps, common to all opcodes; must satisfy 1 ≤ `FETCH_STEPS` < `MAX_STEPS`.
- `RETIRE_WIDTH`, default 16: width of the retired-instruction counter.

Ports (all signals are synchronous to `mclk` except `i_reset`):

- `mclk` — input, 1 — system clock. All state updates on the falling edge, qualified by `mclk_en`.
- `i_reset` — input, 1 — asynchronous, active-high reset.
- `mclk_en` — input, 1 — clock enable. No state changes when low.
- `i_len` — input, STEP_WIDTH+1 — step count of the current instruction from the decoder. Sampled only when `o_step` ≥ `FETCH_STEPS`.
- `i_adv` — input, 1 — early end-of-instruction; the current step becomes the last step.
- `i_stall` — input, 1 — wait state; hold the current step.
- `i_halt` — input, 1 — HLT decoded; enter HALT at the end of the current step.
- `i_resume` — input, 1 — leave HALT.
- `i_single` — input, 1 — single-step mode select.
- `i_step_req` — input, 1 — single-step request; one step per request pulse.
- `o_step` — output, STEP_WIDTH — current step index.
- `o_fetch` — output, 1 — high while `o_step` < `FETCH_STEPS`.
- `o_last` — output, 1 — combinational: the current step is the last step of the instruction.
- `o_retire` — output, 1 — one-`mclk_en`-tick pulse after an instruction completes.
- `o_retired` — output, RETIRE_WIDTH — count of completed instructions; wraps modulo 2^`RETIRE_WIDTH`.
- `o_halted` — output, 1 — state is HALT.
- `o_paused` — output, 1 — state is PAUSE, waiting for `i_step_req`.

## Operation

States: RUN, PAUSE, HALT. The reset state is RUN.

Effective length `L`:

- `i_len` clamped to the range [`FETCH_STEPS`+1, `MAX_STEPS`].
- `i_len` = 0 or `i_len` > `MAX_STEPS` gives `L` = `MAX_STEPS`.

Last-step condition, combinational (`o_last`):

- `o_step == MAX_STEPS-1`, or
- `i_adv`, or
- `o_step ≥ FETCH_STEPS` and `o_step == L-1`.

The "step" event is `mclk_en & (state==RUN) & ~i_stall`. It is further gated by `i_step_req` when `i_single` is set.

On a step event:

- If `o_last`: `o_step` ← 0, `o_retired` ← `o_retired`+1, `o_retire` ← 1.
- Otherwise: `o_step` ← `o_step`+1.
- If `i_single` is set, the next state is PAUSE.
- If `i_halt` is also set, the next state is HALT; HALT takes priority over PAUSE. The step/wrap still completes, and the halted instruction is counted as retired.

Other transitions and rules:

- RUN with `i_single` set and no `i_step_req`: `o_step` holds and the state stays RUN, i.e. waiting. `o_paused` is 0 in this case.
- PAUSE → RUN when `mclk_en & ~i_single` (mode exited), or `mclk_en & i_step_req` with no step taken that tick. A step request in PAUSE therefore first returns to RUN; the step occurs on the next qualifying request or immediately if `i_single` is low.
- HALT → RUN on `mclk_en & i_resume`; `o_step` is unchanged (0 if the HLT instruction wrapped). In HALT all of `i_adv`, `i_stall`, `i_step_req`, and `i_halt` are ignored.
- `i_stall` overrides `i_adv` and `i_halt`: nothing changes during a stall, including halt entry.
- `o_retire` is cleared on any `mclk_en` tick without a retiring step.
- Steps never exceed `MAX_STEPS-1`; `o_step` never holds an illegal value.

## Timing

- Reset (asynchronous, immediate):
  - `o_step` = 0, `o_retired` = 0, `o_retire` = 0, state = RUN.
  - `o_halted` = 0, `o_paused` = 0, `o_fetch` = 1.
  - Reset asserted mid-instruction or mid-HALT aborts it; the count is not incremented.
- Deassertion of `i_reset` is synchronised by the system reset tree. The first falling edge after release may already step.
- All registered outputs change only on the falling edge of `mclk` with `mclk_en` high. `o_last` and `o_fetch` are combinational from registered state plus `i_len`/`i_adv`.
- Step latency is one `mclk_en` tick per step; no bubbles between instructions. Step 0 of the next instruction follows the last step immediately.
- `o_retire` is high for exactly the `mclk_en` tick following the retiring edge.
- When `mclk_en` is low, every register holds, including `o_retire`.

## Test plan

1. Reset mid-instruction, with `MAX_STEPS`=8, `FETCH_STEPS`=2, `i_len`=0: run 3 steps, assert `i_reset` → `o_step`=0, `o_retired`=0 at once. Then run 8 ticks → `o_step` goes 0..7, 0; `o_retire` pulses once; `o_retired`=1.
2. Variable length, `i_len`=4: `o_step` goes 0,1,2,3,0. `o_last` is high only at step 3. With `i_len`=1 (clamped to 3), the sequence is 0,1,2,0.
3. `i_adv` at step 1 (fetch) → `o_step` wraps to 0 and retires. `i_adv` together with `i_stall` → step holds; no retire.
4. `i_halt` at step 3 with `i_len`=4 → `o_step`=0, `o_halted`=1, `o_retired`+1. Ten further ticks with `i_step_req`/`i_adv` → no change. `i_resume` → RUN, and stepping continues from 0.
5. `i_single`=1 with three single-tick `i_step_req` pulses spaced 5 ticks apart → exactly one step per effective request; `o_paused` behaves as specified; `o_step` never advances without a request.
6. `RETIRE_WIDTH`=4, run 17 instructions → `o_retired` wraps to 1. `mclk_en` held low for 20 edges mid-run → all outputs frozen.
